// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (optional even parity via UART_RX_PARITY_EN) feeding a small byte FIFO.
// Latency: byte visible on rd_vld/rd_ch the cycle after the stop-bit sample edge.
// Backpressure: none on the line; a byte completed while the FIFO is full (and not popped) is dropped with an overflow pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    output logic       rd_vld,
    output logic [7:0] rd_ch,
    output logic       frame_err,
    output logic       overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic          rx_meta, rx_s;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          push, bad;
`ifdef UART_RX_PARITY_EN
    logic          par_bad, par_bad_nx;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, pop, wr;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nx;
`endif
        end
    end

    // Next-state logic: bit timing counter, mid-bit sampling, frame completion.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        push     = 1'b0;
        bad      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nx = par_bad;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    cnt_nx   = CNT_HALF;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        state_nx = DATA;
                        idx_nx   = 3'd0;
                        cnt_nx   = CNT_FULL;
                    end else begin
                        state_nx = IDLE;    // start bit vanished: glitch, not an error
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_nx[idx] = rx_s;
                    cnt_nx        = CNT_FULL;
                    idx_nx        = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt == '0) begin
                    par_bad_nx = rx_s ^ (^shreg);   // even parity: data plus parity bit has an even count of ones
                    cnt_nx     = CNT_FULL;
                    state_nx   = STOP;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
`else
                state_nx = IDLE;
`endif
            end
            STOP: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (rx_s && !par_bad) push = 1'b1;
                    else                  bad  = 1'b1;
`else
                    if (rx_s) push = 1'b1;
                    else      bad  = 1'b1;
`endif
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop    = rd_en && !empty;
    assign wr     = push && (!full || pop);   // a simultaneous pop frees the slot being written
    assign rd_vld = !empty;
    assign rd_ch  = empty ? 8'h00 : mem[rptr[AW-1:0]];

    // FIFO pointers; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= shreg;
    end

    // Single-cycle error/overflow pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= bad;
            overflow  <= push && full && !pop;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a byte scoreboard.
// Frames are driven bit by bit; expected bytes are queued at send time and compared on pop.
// Error/overflow pulses are counted by a negedge monitor that also flags any pulse longer than one cycle.
module tb_uart_rx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       rd_vld;
    logic [7:0] rd_ch;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, ov_cnt = 0, long_cnt = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0;
    logic [7:0] sb [$];
    int base;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_vld    (rd_vld),
        .rd_ch     (rd_ch),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Pulse monitor.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow)  ov_cnt++;
        if ((frame_err && fe_prev) || (overflow && ov_prev)) long_cnt++;
        fe_prev = frame_err;
        ov_prev = overflow;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ !par_ok);
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for data, compare head with scoreboard, then pop it.
    task automatic pop_check(input string name);
        logic [7:0] exp;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!rd_vld && waited < 20 * CPB) begin
            @(negedge clk);
            waited++;
        end
        chk({name, "_vld"}, {31'd0, rd_vld}, 32'd1);
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            chk(name, {24'd0, rd_ch}, {24'd0, exp});
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(3);
        chk("rst_vld", {31'd0, rd_vld}, 32'd0);
        chk("rst_ch", {24'd0, rd_ch}, 32'd0);
        chk("rst_fe", {31'd0, frame_err}, 32'd0);
        chk("rst_ov", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Good byte: latency and content
        base = fe_cnt;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        @(negedge clk);
        chk("a5_not_early", {31'd0, rd_vld}, 32'd0);
        @(negedge clk);
        chk("a5_latency", {31'd0, rd_vld}, 32'd1);
        pop_check("a5_data");
        chk("a5_no_fe", fe_cnt - base, 32'd0);
        @(negedge clk);
        chk("a5_empty", {31'd0, rd_vld}, 32'd0);
        idle(2);

        // Bad stop bit
        base = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(6 * CPB);
        chk("stop0_fe", fe_cnt - base, 32'd1);
        chk("stop0_vld", {31'd0, rd_vld}, 32'd0);

        // One-cycle glitch while idle
        base = fe_cnt;
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(12 * CPB);
        chk("glitch_vld", {31'd0, rd_vld}, 32'd0);
        chk("glitch_fe", fe_cnt - base, 32'd0);

        // Overflow: five bytes, no pops
        base = ov_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) sb.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b1);
        end
        idle(3);
        chk("ovf_pulse", ov_cnt - base, 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check("ovf_pop");
        @(negedge clk);
        chk("ovf_drained", {31'd0, rd_vld}, 32'd0);
        idle(2);

        // Full FIFO: pop in the same cycle as the fifth push
        base = ov_cnt;
        for (int i = 1; i <= 5; i++) sb.push_back(8'(i));
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1);
        send_frame(8'h05, 1'b1, 1'b1);
        chk("same_cyc_head", {24'd0, rd_ch}, {24'd0, sb.pop_front()});
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        idle(3);
        chk("same_cyc_no_ovf", ov_cnt - base, 32'd0);
        for (int i = 0; i < 4; i++) pop_check("same_cyc_pop");
        @(negedge clk);
        chk("same_cyc_drained", {31'd0, rd_vld}, 32'd0);

        // rd_en while empty is ignored
        rd_en = 1'b1;
        idle(2);
        rd_en = 1'b0;
        sb.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b1);
        pop_check("empty_pop_ignored");

`ifdef UART_RX_PARITY_EN
        // Parity accept / reject
        base = fe_cnt;
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        pop_check("par_ok");
        send_frame(8'h07, 1'b1, 1'b0);
        idle(6 * CPB);
        chk("par_bad_fe", fe_cnt - base, 32'd1);
        chk("par_bad_vld", {31'd0, rd_vld}, 32'd0);
`endif

        // Reset in the middle of DATA abandons the byte
        base = fe_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        rx = 1'b1;
        idle(3);
        chk("midrst_vld", {31'd0, rd_vld}, 32'd0);
        rst_n = 1'b1;
        idle(15 * CPB);
        chk("midrst_no_push", {31'd0, rd_vld}, 32'd0);
        chk("midrst_no_fe", fe_cnt - base, 32'd0);
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1);
        pop_check("midrst_recover");

        idle(2);
        chk("pulse_width", long_cnt, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
